// File: rtl/kl8e_tty.sv
// KL8E-style console controller: decodes keyboard/printer IOTs, owns the buffers,
// flags and interrupt enable, and runs the req/ack handshakes toward the uart.
module kl8e_tty #(
  parameter logic [5:0] KBD_DEV     = 6'o03,
  parameter logic [5:0] PRT_DEV     = 6'o04,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [5:0]  io_dev,
  input  logic [2:0]  io_op,
  input  logic        io_caf,
  input  logic [11:0] ac_in,
  output logic [11:0] io_data,
  output logic        io_data_en,
  output logic        io_ac_clr,
  output logic        io_skip,
  output logic        io_int,
  output logic        tx_req,
  output logic [7:0]  tx_data,
  input  logic        tx_ack,
  input  logic        tx_empty,
  output logic        rx_req,
  input  logic [7:0]  rx_data,
  input  logic        rx_ack,
  input  logic        rx_empty
);

  typedef enum logic [1:0] {RX_IDLE, RX_REQ, RX_CAP, RX_DROP} rx_st_e;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_DROP, TX_BUSY} tx_st_e;

  // bit order {tx_empty, tx_ack, rx_empty, rx_ack}; empties idle high
  localparam logic [3:0] SYNC_RST = 4'b1010;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic rx_ack_s, rx_empty_s, tx_ack_s, tx_empty_s;

  rx_st_e      rx_st_q, rx_st_d;
  tx_st_e      tx_st_q, tx_st_d;
  logic [7:0]  kbd_buf_q, kbd_buf_d;
  logic [7:0]  prt_buf_q, prt_buf_d;
  logic        kbd_flag_q, kbd_flag_d;
  logic        prt_flag_q, prt_flag_d;
  logic        int_en_q, int_en_d;
  logic        tx_pend_q, tx_pend_d;
  logic        rx_req_q, rx_req_d;
  logic        tx_req_q, tx_req_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [11:0] io_data_q, io_data_d;
  logic        io_data_en_q, io_data_en_d;
  logic        io_ac_clr_q, io_ac_clr_d;
  logic        io_skip_q, io_skip_d;
  logic        io_int_q, io_int_d;

  logic kbd_hit, prt_hit;
  logic kbd_clr, prt_clr, prt_set_iot, prt_set_fsm, rx_set, tx_start;
  logic unused_ac;

  // high AC bits carry nothing for this device
  assign unused_ac = ^ac_in[11:8];

  assign rx_ack_s   = sync_q[SYNC_STAGES-1][0];
  assign rx_empty_s = sync_q[SYNC_STAGES-1][1];
  assign tx_ack_s   = sync_q[SYNC_STAGES-1][2];
  assign tx_empty_s = sync_q[SYNC_STAGES-1][3];

  assign kbd_hit = iot && (io_dev == KBD_DEV);
  assign prt_hit = iot && (io_dev == PRT_DEV);

  always_comb begin
    sync_d[0] = {tx_empty, tx_ack, rx_empty, rx_ack};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    rx_st_d      = rx_st_q;
    tx_st_d      = tx_st_q;
    kbd_buf_d    = kbd_buf_q;
    prt_buf_d    = prt_buf_q;
    kbd_flag_d   = kbd_flag_q;
    prt_flag_d   = prt_flag_q;
    int_en_d     = int_en_q;
    tx_pend_d    = tx_pend_q;
    rx_req_d     = rx_req_q;
    tx_req_d     = tx_req_q;
    tx_data_d    = tx_data_q;
    io_data_d    = '0;
    io_data_en_d = 1'b0;
    io_ac_clr_d  = 1'b0;
    io_skip_d    = 1'b0;
    kbd_clr      = 1'b0;
    prt_clr      = 1'b0;
    prt_set_iot  = 1'b0;
    prt_set_fsm  = 1'b0;
    rx_set       = 1'b0;
    tx_start     = 1'b0;

    // skip/data always reflect state before this IOT's own update
    if (kbd_hit) begin
      case (io_op)
        3'd0: kbd_clr = 1'b1;
        3'd1: io_skip_d = kbd_flag_q;
        3'd2: begin kbd_clr = 1'b1; io_ac_clr_d = 1'b1; end
        3'd4: begin io_data_d = {4'b0, kbd_buf_q}; io_data_en_d = 1'b1; end
        3'd5: int_en_d = ac_in[0];
        3'd6: begin
          kbd_clr      = 1'b1;
          io_ac_clr_d  = 1'b1;
          io_data_d    = {4'b0, kbd_buf_q};
          io_data_en_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (prt_hit) begin
      case (io_op)
        3'd0: prt_set_iot = 1'b1;
        3'd1: io_skip_d = prt_flag_q;
        3'd2: prt_clr = 1'b1;
        3'd4: tx_start = 1'b1;
        3'd5: io_skip_d = kbd_flag_q | prt_flag_q;
        3'd6: begin prt_clr = 1'b1; tx_start = 1'b1; end
        default: ;
      endcase
    end
    if (tx_start) prt_buf_d = ac_in[7:0];
    if (io_caf) int_en_d = 1'b1;

    case (rx_st_q)
      RX_IDLE: if (!rx_empty_s && !kbd_flag_q) begin
        rx_st_d  = RX_REQ;
        rx_req_d = 1'b1;
      end
      RX_REQ: if (rx_ack_s) begin
        rx_st_d  = RX_CAP;
        rx_req_d = 1'b0;
      end
      RX_CAP: begin
        kbd_buf_d = rx_data;
        rx_set    = 1'b1;
        rx_st_d   = RX_DROP;
      end
      default: if (!rx_ack_s) rx_st_d = RX_IDLE;
    endcase

    // a start while the transmitter is occupied is remembered in tx_pend;
    // a start landing on the BUSY->done cycle chains straight into REQ
    case (tx_st_q)
      TX_IDLE: if (tx_start) begin
        tx_st_d   = TX_REQ;
        tx_req_d  = 1'b1;
        tx_data_d = prt_buf_d;
      end
      TX_REQ: begin
        if (tx_start) tx_pend_d = 1'b1;
        if (tx_ack_s) begin
          tx_st_d  = TX_DROP;
          tx_req_d = 1'b0;
        end
      end
      TX_DROP: begin
        if (tx_start) tx_pend_d = 1'b1;
        if (!tx_ack_s) tx_st_d = TX_BUSY;
      end
      default: begin
        if (tx_empty_s) begin
          if (tx_pend_q || tx_start) begin
            tx_pend_d = 1'b0;
            tx_st_d   = TX_REQ;
            tx_req_d  = 1'b1;
            tx_data_d = prt_buf_d;
          end else begin
            prt_set_fsm = 1'b1;
            tx_st_d     = TX_IDLE;
          end
        end else if (tx_start) begin
          tx_pend_d = 1'b1;
        end
      end
    endcase

    // hardware-set beats software clear on the same cycle
    if (kbd_clr || io_caf) kbd_flag_d = 1'b0;
    if (rx_set)            kbd_flag_d = 1'b1;
    if (prt_set_iot)       prt_flag_d = 1'b1;
    if (prt_clr || io_caf) prt_flag_d = 1'b0;
    if (prt_set_fsm)       prt_flag_d = 1'b1;

    io_int_d = int_en_q & (kbd_flag_q | prt_flag_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= {SYNC_STAGES{SYNC_RST}};
      rx_st_q      <= RX_IDLE;
      tx_st_q      <= TX_IDLE;
      kbd_buf_q    <= '0;
      prt_buf_q    <= '0;
      kbd_flag_q   <= 1'b0;
      prt_flag_q   <= 1'b0;
      int_en_q     <= 1'b1;
      tx_pend_q    <= 1'b0;
      rx_req_q     <= 1'b0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
      io_data_q    <= '0;
      io_data_en_q <= 1'b0;
      io_ac_clr_q  <= 1'b0;
      io_skip_q    <= 1'b0;
      io_int_q     <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rx_st_q      <= rx_st_d;
      tx_st_q      <= tx_st_d;
      kbd_buf_q    <= kbd_buf_d;
      prt_buf_q    <= prt_buf_d;
      kbd_flag_q   <= kbd_flag_d;
      prt_flag_q   <= prt_flag_d;
      int_en_q     <= int_en_d;
      tx_pend_q    <= tx_pend_d;
      rx_req_q     <= rx_req_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      io_data_q    <= io_data_d;
      io_data_en_q <= io_data_en_d;
      io_ac_clr_q  <= io_ac_clr_d;
      io_skip_q    <= io_skip_d;
      io_int_q     <= io_int_d;
    end
  end

  assign io_data    = io_data_q;
  assign io_data_en = io_data_en_q;
  assign io_ac_clr  = io_ac_clr_q;
  assign io_skip    = io_skip_q;
  assign io_int     = io_int_q;
  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign rx_req     = rx_req_q;

endmodule

// File: tb/tb_kl8e_tty.sv
// Directed bench for kl8e_tty: IOT ops, uart rx/tx handshakes, flag/interrupt rules, reset.
module tb_kl8e_tty;
  logic        clk = 1'b0;
  logic        reset;
  logic        iot, io_caf;
  logic [5:0]  io_dev;
  logic [2:0]  io_op;
  logic [11:0] ac_in;
  logic [11:0] io_data;
  logic        io_data_en, io_ac_clr, io_skip, io_int;
  logic        tx_req, tx_ack, tx_empty;
  logic [7:0]  tx_data, rx_data;
  logic        rx_req, rx_ack, rx_empty;

  int total = 0;
  int bad   = 0;

  kl8e_tty dut (
    .clk(clk), .reset(reset), .iot(iot), .io_dev(io_dev), .io_op(io_op),
    .io_caf(io_caf), .ac_in(ac_in), .io_data(io_data), .io_data_en(io_data_en),
    .io_ac_clr(io_ac_clr), .io_skip(io_skip), .io_int(io_int),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .tx_empty(tx_empty),
    .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // drive one IOT at a negedge, sample the registered response one cycle later
  task automatic do_iot(input logic [5:0] dev, input logic [2:0] op, input logic [11:0] ac,
                        output logic sk, output logic [11:0] d, output logic den,
                        output logic clr);
    @(negedge clk);
    iot = 1'b1; io_dev = dev; io_op = op; ac_in = ac;
    @(negedge clk);
    iot = 1'b0;
    sk = io_skip; d = io_data; den = io_data_en; clr = io_ac_clr;
  endtask

  task automatic wait_rx_req(input logic v, output int n);
    n = 0;
    while (rx_req !== v && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic wait_tx_req(input logic v, output int n);
    n = 0;
    while (tx_req !== v && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic uart_rx(input logic [7:0] ch, output int lat);
    int n;
    @(negedge clk);
    rx_data = ch; rx_empty = 1'b0;
    wait_rx_req(1'b1, lat);
    chk("rx_req_up", {31'b0, lat < 20}, 1);
    rx_ack = 1'b1;
    wait_rx_req(1'b0, n);
    chk("rx_req_down", {31'b0, n < 20}, 1);
    rx_ack = 1'b0; rx_empty = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // leaves tx_empty low (uart shifting); caller decides when it goes idle
  task automatic uart_tx(output logic [7:0] got);
    int n;
    wait_tx_req(1'b1, n);
    chk("tx_req_up", {31'b0, n < 20}, 1);
    got = tx_data;
    repeat (3) @(negedge clk);
    chk("tx_req_hold", {31'b0, tx_req}, 1);
    chk("tx_data_hold", {24'b0, tx_data}, {24'b0, got});
    tx_ack = 1'b1; tx_empty = 1'b0;
    wait_tx_req(1'b0, n);
    chk("tx_req_down", {31'b0, n < 20}, 1);
    tx_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic sk, den, clr;
    logic [11:0] d;
    logic [7:0] got1, got2;
    int lat;

    reset = 1'b0; iot = 1'b0; io_caf = 1'b0; io_dev = '0; io_op = '0; ac_in = '0;
    tx_ack = 1'b0; tx_empty = 1'b1; rx_ack = 1'b0; rx_empty = 1'b1; rx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_io_int", {31'b0, io_int}, 0);
    chk("rst_io_data", {20'b0, io_data}, 0);
    chk("rst_tx_req", {31'b0, tx_req}, 0);
    chk("rst_rx_req", {31'b0, rx_req}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // keyboard receive and KSF/KRB
    uart_rx(8'o215, lat);
    chk("rx_req_lat", lat, 3);
    chk("kbd_io_int", {31'b0, io_int}, 1);
    do_iot(6'o03, 3'd1, 12'o0, sk, d, den, clr);
    chk("ksf_skip", {31'b0, sk}, 1);
    do_iot(6'o03, 3'd6, 12'o0, sk, d, den, clr);
    chk("krb_data", {20'b0, d}, 32'o0215);
    chk("krb_en", {31'b0, den}, 1);
    chk("krb_clr", {31'b0, clr}, 1);
    chk("krb_skip", {31'b0, sk}, 0);
    @(negedge clk);
    chk("iot_pulse_data", {20'b0, io_data}, 0);
    chk("iot_pulse_clr", {31'b0, io_ac_clr}, 0);
    do_iot(6'o03, 3'd1, 12'o0, sk, d, den, clr);
    chk("ksf_after_krb", {31'b0, sk}, 0);
    chk("ksf_no_data", {31'b0, den}, 0);

    // TLS and printer handshake
    do_iot(6'o04, 3'd6, 12'o7301, sk, d, den, clr);
    chk("tls_tx_req", {31'b0, tx_req}, 1);
    uart_tx(got1);
    chk("tls_tx_data", {24'b0, got1}, 32'o301);
    do_iot(6'o04, 3'd1, 12'o0, sk, d, den, clr);
    chk("tsf_busy", {31'b0, sk}, 0);
    tx_empty = 1'b1;
    repeat (5) @(negedge clk);
    do_iot(6'o04, 3'd1, 12'o0, sk, d, den, clr);
    chk("tsf_done", {31'b0, sk}, 1);

    // both flags set, KIE off, TSK, CAF
    uart_rx(8'o101, lat);
    chk("int_both", {31'b0, io_int}, 1);
    do_iot(6'o03, 3'd5, 12'o0, sk, d, den, clr);
    repeat (2) @(negedge clk);
    chk("kie_off_int", {31'b0, io_int}, 0);
    do_iot(6'o04, 3'd5, 12'o0, sk, d, den, clr);
    chk("tsk_skip", {31'b0, sk}, 1);
    @(negedge clk); io_caf = 1'b1;
    @(negedge clk); io_caf = 1'b0;
    do_iot(6'o03, 3'd1, 12'o0, sk, d, den, clr);
    chk("caf_kflag", {31'b0, sk}, 0);
    do_iot(6'o04, 3'd1, 12'o0, sk, d, den, clr);
    chk("caf_pflag", {31'b0, sk}, 0);
    do_iot(6'o04, 3'd0, 12'o0, sk, d, den, clr);
    repeat (2) @(negedge clk);
    chk("caf_int_en", {31'b0, io_int}, 1);
    do_iot(6'o04, 3'd2, 12'o0, sk, d, den, clr);
    repeat (2) @(negedge clk);
    chk("tcf_int", {31'b0, io_int}, 0);

    // second TPC while busy is deferred, one flag set at the end
    do_iot(6'o04, 3'd4, 12'o0101, sk, d, den, clr);
    uart_tx(got1);
    chk("tpc1_data", {24'b0, got1}, 32'o101);
    do_iot(6'o04, 3'd4, 12'o0102, sk, d, den, clr);
    tx_empty = 1'b1;
    repeat (4) @(negedge clk);
    do_iot(6'o04, 3'd1, 12'o0, sk, d, den, clr);
    chk("tpc_mid_flag", {31'b0, sk}, 0);
    uart_tx(got2);
    chk("tpc2_data", {24'b0, got2}, 32'o102);
    do_iot(6'o04, 3'd1, 12'o0, sk, d, den, clr);
    chk("tpc2_busy_flag", {31'b0, sk}, 0);
    tx_empty = 1'b1;
    repeat (5) @(negedge clk);
    do_iot(6'o04, 3'd1, 12'o0, sk, d, den, clr);
    chk("tpc2_flag", {31'b0, sk}, 1);

    // no fetch while kbd_flag set; KCF releases it
    uart_rx(8'o102, lat);
    @(negedge clk); rx_data = 8'o103; rx_empty = 1'b0;
    repeat (6) @(negedge clk);
    chk("rx_hold_off", {31'b0, rx_req}, 0);
    do_iot(6'o03, 3'd0, 12'o0, sk, d, den, clr);
    @(negedge clk);
    chk("kcf_refetch", {31'b0, rx_req}, 1);
    rx_ack = 1'b1;
    wait_rx_req(1'b0, lat);
    chk("rx2_down", {31'b0, lat < 20}, 1);
    rx_ack = 1'b0; rx_empty = 1'b1;
    repeat (4) @(negedge clk);
    do_iot(6'o03, 3'd4, 12'o0, sk, d, den, clr);
    chk("krs_data", {20'b0, d}, 32'o0103);
    chk("krs_no_clr", {31'b0, clr}, 0);
    do_iot(6'o03, 3'd3, 12'o0, sk, d, den, clr);
    chk("op3_none", {19'b0, sk, d}, 0);

    // async reset in the middle of TX REQ
    do_iot(6'o04, 3'd4, 12'o0055, sk, d, den, clr);
    chk("pre_rst_tx_req", {31'b0, tx_req}, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_tx_req", {31'b0, tx_req}, 0);
    chk("rst_mid_int", {31'b0, io_int}, 0);
    @(negedge clk); reset = 1'b1;
    do_iot(6'o03, 3'd1, 12'o0, sk, d, den, clr);
    chk("rst_kflag", {31'b0, sk}, 0);
    do_iot(6'o04, 3'd1, 12'o0, sk, d, den, clr);
    chk("rst_pflag", {31'b0, sk}, 0);
    chk("rst_tx_idle", {31'b0, tx_req}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
